rsa_modexp_engine: RTL and testbench
====================================

// Module: rsa_modexp_engine
// PURPOSE
//  Parametrised modular exponentiation engine: result = base^exponent mod modulus.
//  Successor to the 16-bit repeated-add exponent and repeated-subtract modulo pair.
//  Replaces them with bit-serial square-and-multiply using interleaved (Blakley) modular multiply.
//  Latency is bounded by the operand widths, not their values; sits under the RSA top-level controller.
// PARAMETERS
//  WIDTH    16  bit width of base, modulus and result
//  EXP_W    16  bit width of exponent (private/public key)
// PORTS
//  clk       in   1        rising-edge clock
//  Rst       in   1        synchronous active-high reset
//  start     in   1        request; sampled only in IDLE
//  base      in   WIDTH    message value (may be >= modulus)
//  exponent  in   EXP_W    key exponent
//  modulus   in   WIDTH    modulus n
//  busy      out  1        high from the cycle after start is accepted until done
//  done      out  1        one-cycle pulse; result valid from this cycle on
//  result    out  WIDTH    base^exponent mod modulus; held until next accepted start
//  err       out  1        only with RSA_MODEXP_MODCHK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result=0, err=0. Reset mid-operation aborts; no done pulse.
//  - One clock domain, synchronous reset only.
//  - IDLE: if start, latch base/exponent/modulus into internal regs; go to REDUCE.
//    Start while busy is ignored; input changes after acceptance have no effect.
//  - REDUCE (WIDTH cycles): restoring shift-subtract gives B = base mod modulus.
//    R initialised to 1 mod modulus (0 when modulus==1).
//  - Exponent scan MSB to LSB over all EXP_W bits; leading zeros are not skipped.
//    SQR (WIDTH cycles): R = R*R mod n.
//    MUL (WIDTH cycles, only if the current bit is 1): R = R*B mod n.
//  - Blakley step, one multiplier bit per cycle, MSB first: P=2P; if a[i] then P+=b;
//    then subtract n at most twice while P>=n. P is WIDTH+2 bits wide; no overflow allowed.
//  - After the LSB: DONE state for 1 cycle. done=1, busy=0, result=R. Then back to IDLE.
//  - Latency: done asserts exactly 2 + WIDTH*(1 + EXP_W + popcount(exponent)) cycles
//    after the start-sampling edge.
//  - start in the DONE cycle is ignored. start in the cycle after DONE is accepted (back-to-back).
//  - exponent==0: result = 1 mod n. modulus==1: result = 0.
//  - modulus==0 without the check: the engine still terminates at the nominal latency;
//    the result value is don't-care.
//  - All operand arithmetic is unsigned.
// CONFIGURATION
//  RSA_MODEXP_MODCHK_EN defined:
//    err port exists. If the latched modulus==0, skip REDUCE and the scan, go straight to DONE.
//    done pulses 2 cycles after the start-sampling edge with err=1 and result=0.
//    err is held until the next accepted start and cleared on that start and on Rst.
//  RSA_MODEXP_MODCHK_EN undefined:
//    no err port; modulus==0 behaves as described in BEHAVIOUR.
// TESTING
//  1 WIDTH=16,EXP_W=16: base=9, exp=3, mod=33 -> result=3, done exactly 2+16*(1+16+2)=306 cycles after start.
//  2 base=4, exp=13, mod=497 -> result=445. base=100, exp=2, mod=7 -> 4 (base>=mod path).
//  3 base=7, exp=0, mod=10 -> result=1. base=5, exp=9, mod=1 -> result=0.
//  4 Second start pulsed 5 cycles after acceptance with new operands -> ignored; first result unchanged.
//    Start the cycle after done -> accepted and correct.
//  5 Rst asserted mid-scan -> next cycle busy=0, done=0, result=0. A new start then yields 9^3 mod 33 = 3.
//  6 RSA_MODEXP_MODCHK_EN, mod=0 -> done 2 cycles after start, err=1, result=0.
//    Next valid start clears err.

Source files
------------

// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine: result = base^exponent mod modulus.
// Bit-serial square-and-multiply over every exponent bit (MSB first), with an
// interleaved (Blakley) modular multiply that consumes one multiplier bit per cycle.
// Optional macro RSA_MODEXP_MODCHK_EN adds the err port and the modulus==0 early exit.
module rsa_modexp_engine #(
    parameter int WIDTH = 16,
    parameter int EXP_W = 16
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef RSA_MODEXP_MODCHK_EN
    ,
    output logic             err
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int EW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int PW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_FINISH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]    ebit_q, ebit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
`ifdef RSA_MODEXP_MODCHK_EN
    logic             err_q, err_d;
`endif

    logic [PW-1:0]    mod_ext;
    logic [PW-1:0]    red_shift, red_next;
    logic [WIDTH-1:0] mul_b;
    logic [PW-1:0]    mul_sum, mul_sub1, blk_next;

    // Datapath: one restoring-division step for REDUCE and one Blakley step for SQR/MUL.
    always_comb begin
        mod_ext   = {2'b00, mod_q};
        red_shift = (p_q << 1) | {{(PW-1){1'b0}}, base_q[cnt_q]};
        red_next  = (red_shift >= mod_ext) ? (red_shift - mod_ext) : red_shift;
        mul_b     = (state_q == S_MUL) ? b_q : r_q;
        mul_sum   = (p_q << 1) + (r_q[cnt_q] ? {2'b00, mul_b} : {PW{1'b0}});
        mul_sub1  = (mul_sum >= mod_ext) ? (mul_sum - mod_ext) : mul_sum;
        blk_next  = (mul_sub1 >= mod_ext) ? (mul_sub1 - mod_ext) : mul_sub1;
    end

    // Next-state and next-register computation for the whole engine.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        b_d      = b_q;
        r_d      = r_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        ebit_d   = ebit_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
`ifdef RSA_MODEXP_MODCHK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exponent;
                    mod_d   = modulus;
                    busy_d  = 1'b1;
`ifdef RSA_MODEXP_MODCHK_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                r_d   = (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                p_d   = '0;
                cnt_d = CW'(WIDTH - 1);
`ifdef RSA_MODEXP_MODCHK_EN
                state_d = (mod_q == '0) ? S_FINISH : S_REDUCE;
`else
                state_d = S_REDUCE;
`endif
            end
            S_REDUCE: begin
                p_d = red_next;
                if (cnt_q == '0) begin
                    b_d     = red_next[WIDTH-1:0];
                    p_d     = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    ebit_d  = EW'(EXP_W - 1);
                    state_d = S_SQR;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SQR, S_MUL: begin
                p_d = blk_next;
                if (cnt_q == '0) begin
                    r_d   = blk_next[WIDTH-1:0];
                    p_d   = '0;
                    cnt_d = CW'(WIDTH - 1);
                    if ((state_q == S_SQR) && exp_q[ebit_q]) begin
                        state_d = S_MUL;
                    end else if (ebit_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        ebit_d  = ebit_q - EW'(1);
                        state_d = S_SQR;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FINISH: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                result_d = r_q;
`ifdef RSA_MODEXP_MODCHK_EN
                if (mod_q == '0) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single state register: synchronous reset aborts any operation without a done pulse.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            b_q      <= '0;
            r_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            ebit_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef RSA_MODEXP_MODCHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            b_q      <= b_d;
            r_q      <= r_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            ebit_q   <= ebit_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
`ifdef RSA_MODEXP_MODCHK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
`ifdef RSA_MODEXP_MODCHK_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb_rsa_modexp_engine: directed vectors for rsa_modexp_engine (WIDTH=16, EXP_W=16).
// Checks result values, exact done latency, busy/done framing, start-while-busy,
// back-to-back start after done, and mid-operation reset.
module tb_rsa_modexp_engine;

    logic        clk;
    logic        Rst;
    logic        start;
    logic [15:0] base;
    logic [15:0] exponent;
    logic [15:0] modulus;
    logic        busy;
    logic        done;
    logic [15:0] result;
`ifdef RSA_MODEXP_MODCHK_EN
    logic        err;
`endif

    int checkCount;
    int failCount;

    typedef struct {
        logic [15:0] vBase;
        logic [15:0] vExp;
        logic [15:0] vMod;
        logic [15:0] vResult;
        int          vLatency;
    } vec_t;

    vec_t vecs[10];

    rsa_modexp_engine #(.WIDTH(16), .EXP_W(16)) dut (
        .clk      (clk),
        .Rst      (Rst),
        .start    (start),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef RSA_MODEXP_MODCHK_EN
        ,
        .err      (err)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m);
        base     = b;
        exponent = e;
        modulus  = m;
        start    = 1'b1;
    endtask

    // Called #1 after the accepting edge; counts edges until done, optionally
    // injecting a start pulse with other operands while the engine is busy.
    task automatic waitDone(input string tag, input int expLatency, input logic [15:0] expResult,
                            input int injectAt);
        int cycles;
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == injectAt) begin
                applyStimulus(16'd4, 16'd13, 16'd497);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({tag, " done seen"}, 32'(done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({tag, " result"}, 32'(result), 32'(expResult));
        checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    task automatic runVec(input string tag, input vec_t v, input int injectAt);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(v.vBase, v.vExp, v.vMod);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        waitDone(tag, v.vLatency, v.vResult, injectAt);
    endtask

    initial begin
        vec_t v;
        checkCount = 0;
        failCount  = 0;
        Rst      = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        modulus  = '0;

        // Hand-computed vectors; latency = 2 + 16*(17 + popcount(exponent)).
        vecs[0] = '{16'd9,     16'd3,  16'd33,    16'd3,     306};
        vecs[1] = '{16'd4,     16'd13, 16'd497,   16'd445,   322};
        vecs[2] = '{16'd100,   16'd2,  16'd7,     16'd4,     290};
        vecs[3] = '{16'd7,     16'd0,  16'd10,    16'd1,     274};
        vecs[4] = '{16'd5,     16'd9,  16'd1,     16'd0,     306};
        vecs[5] = '{16'd2,     16'd10, 16'd1000,  16'd24,    306};
        vecs[6] = '{16'd3,     16'd5,  16'd7,     16'd5,     306};
        vecs[7] = '{16'd65535, 16'd1,  16'd65535, 16'd0,     290};
        vecs[8] = '{16'd65535, 16'd2,  16'd65534, 16'd1,     290};
        vecs[9] = '{16'd65534, 16'd2,  16'd65535, 16'd1,     290};

        repeat (3) @(posedge clk);
        @(negedge clk);
        Rst = 1'b0;
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
`ifdef RSA_MODEXP_MODCHK_EN
        checkOutput("reset err", 32'(err), 32'd0);
`endif

        for (int i = 0; i < 10; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i], -1);
        end

        // Start pulsed while busy with different operands must be ignored.
        runVec("ignore-busy", vecs[0], 5);

        // Start held in the done cycle is ignored, then accepted the cycle after.
        @(negedge clk);
        applyStimulus(16'd4, 16'd13, 16'd497);
        @(posedge clk);
        #1;
        checkOutput("b2b done cycle ignored busy", 32'(busy), 32'd0);
        checkOutput("b2b done low", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b accepted busy", 32'(busy), 32'd1);
        waitDone("b2b", 322, 16'd445, -1);

        // Reset in the middle of the scan aborts cleanly.
        @(negedge clk);
        @(negedge clk);
        applyStimulus(16'd9, 16'd3, 16'd33);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        Rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset result", 32'(result), 32'd0);
        @(negedge clk);
        Rst = 1'b0;
        runVec("after-reset", vecs[0], -1);

`ifdef RSA_MODEXP_MODCHK_EN
        // Zero modulus takes the early exit with err; next valid start clears it.
        v = '{16'd5, 16'd3, 16'd0, 16'd0, 2};
        runVec("mod0", v, -1);
        checkOutput("mod0 err", 32'(err), 32'd1);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(16'd9, 16'd3, 16'd33);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("err cleared on start", 32'(err), 32'd0);
        waitDone("post-mod0", 306, 16'd3, -1);
        checkOutput("post-mod0 err", 32'(err), 32'd0);
`else
        // Zero modulus without the check still finishes at nominal latency.
        @(negedge clk);
        @(negedge clk);
        applyStimulus(16'd5, 16'd3, 16'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        begin
            int cycles;
            cycles = 0;
            while (!done && cycles < 2000) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            checkOutput("mod0 done seen", 32'(done), 32'd1);
            checkOutput("mod0 latency", 32'(cycles), 32'd306);
        end
        v = vecs[1];
        runVec("after-mod0", v, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
